// File: rtl/crypt_feeder_pkg.sv
// Shared types and defaults for the crypt_feeder byte-to-powermod bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package crypt_feeder_pkg;
  localparam int BYTE_W         = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_TMO_CYCLES = 63;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;
endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with registered storage and show-ahead head output.
// Latency: a pushed byte is visible at o_head_dat the cycle after the push.
// Backpressure: o_full is exported; a push while full is discarded, push+pop in one cycle both apply.
module byte_fifo
  import crypt_feeder_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_push_dat,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_head_dat,
  output logic              o_full,
  output logic              o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push  = i_push && !o_full;
  assign w_do_pop   = i_pop && !o_empty;
  assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

  // Pointer advance, wrapping naturally modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end
endmodule

// File: rtl/crypt_feeder.sv
// Feeds buffered bytes one at a time to an external powermod core and returns results in order.
// Latency: ISSUE to out_valid = core latency + 1; back-to-back byte spacing = core latency + 3.
// Backpressure: in_ready drops on FIFO full or bad key; OUT holds until out_ready; core stall aborts after TMO_CYCLES.
module crypt_feeder
  import crypt_feeder_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TMO_CYCLES = DEF_TMO_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_ld,
  input  logic [BYTE_W-1:0] key_e,
  input  logic [BYTE_W-1:0] key_n,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  input  logic              out_ready,
  output logic              pm_start,
  output logic [BYTE_W-1:0] pm_a,
  output logic [BYTE_W-1:0] pm_b,
  output logic [BYTE_W-1:0] pm_m,
  input  logic [BYTE_W-1:0] pm_res,
  input  logic              pm_rdy,
  output logic              busy,
  output logic              cfg_err,
  output logic              tmo_err
);
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BYTE_W-1:0] r_key_e;
  logic [BYTE_W-1:0] r_key_n;
  logic [7:0]        r_tmo_cnt;
  logic              r_out_vld;
  logic [BYTE_W-1:0] r_out_dat;
  logic              r_tmo_err;
  logic              w_push;
  logic              w_pop;
  logic              w_tmo_hit;
  logic              w_key_we;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [BYTE_W-1:0] w_head_dat;

  assign cfg_err   = (r_key_n < 8'd2);
  assign in_ready  = !w_fifo_full && !cfg_err;
  assign w_push    = in_valid && in_ready;
  // Keys only change when nothing is queued or in flight, so operands stay stable per byte.
  assign w_key_we  = key_ld && (r_state == ST_IDLE) && w_fifo_empty;
  assign busy      = (r_state != ST_IDLE) || !w_fifo_empty;
  assign out_valid = r_out_vld;
  assign out_data  = r_out_dat;
  assign tmo_err   = r_tmo_err;
  // Head cannot move before the pm_rdy/timeout pop, so pm_a is stable for the whole transaction.
  assign pm_a      = w_head_dat;
  assign pm_b      = r_key_e;
  assign pm_m      = r_key_n;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .i_push     (w_push),
    .i_push_dat (in_data),
    .i_pop      (w_pop),
    .o_head_dat (w_head_dat),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state, start pulse and FIFO pop decisions; pm_rdy only matters in WAIT.
  always_comb begin
    w_state_nxt = r_state;
    pm_start    = 1'b0;
    w_pop       = 1'b0;
    w_tmo_hit   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty && !cfg_err) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        pm_start    = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (pm_rdy) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_OUT;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_pop       = 1'b1;
          w_tmo_hit   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Key latch, WAIT-cycle counter, result register and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_e   <= '0;
      r_key_n   <= '0;
      r_tmo_cnt <= '0;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      if (w_key_we) begin
        r_key_e <= key_e;
        r_key_n <= key_n;
      end
      if (r_state == ST_ISSUE)     r_tmo_cnt <= '0;
      else if (r_state == ST_WAIT) r_tmo_cnt <= r_tmo_cnt + 8'd1;
      if ((r_state == ST_WAIT) && pm_rdy) begin
        r_out_vld <= 1'b1;
        r_out_dat <= pm_res;
      end else if ((r_state == ST_OUT) && out_ready) begin
        r_out_vld <= 1'b0;
      end
      if (w_tmo_hit) r_tmo_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_crypt_feeder.sv
// Directed bench for crypt_feeder with a behavioural powermod core of programmable latency.
// Latency: n/a.
// Backpressure: out_ready driven per test.
module tb_crypt_feeder;
  logic       clk;
  logic       rst;
  logic       key_ld;
  logic [7:0] key_e, key_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       pm_start;
  logic [7:0] pm_a, pm_b, pm_m;
  logic [7:0] pm_res;
  logic       pm_rdy;
  logic       busy, cfg_err, tmo_err;

  int checks = 0;
  int errors = 0;

  int   core_lat  = 1;
  bit   core_en   = 1'b1;
  bit   skip_stab = 1'b0;
  int   pm_starts = 0;
  logic [7:0] cap_a, cap_b, cap_m;
  logic [7:0] outq[$];

  typedef struct {
    logic [7:0] e;
    logic [7:0] n;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[8];

  crypt_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .key_ld    (key_ld),
    .key_e     (key_e),
    .key_n     (key_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .pm_start  (pm_start),
    .pm_a      (pm_a),
    .pm_b      (pm_b),
    .pm_m      (pm_m),
    .pm_res    (pm_res),
    .pm_rdy    (pm_rdy),
    .busy      (busy),
    .cfg_err   (cfg_err),
    .tmo_err   (tmo_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] modpow(input logic [7:0] a, input logic [7:0] e, input logic [7:0] m);
    int r;
    int b;
    if (m == 8'd0) return 8'd0;
    r = 1 % int'(m);
    b = int'(a) % int'(m);
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = (r * b) % int'(m);
      b = (b * b) % int'(m);
    end
    return 8'(r);
  endfunction

  // Behavioural core: answers each start pulse after core_lat cycles with a one-cycle pm_rdy.
  initial begin
    pm_rdy = 1'b0;
    pm_res = 8'd0;
    forever begin
      @(negedge clk);
      if (pm_start && core_en) begin
        cap_a = pm_a;
        cap_b = pm_b;
        cap_m = pm_m;
        repeat (core_lat) @(posedge clk);
        #1;
        pm_rdy = 1'b1;
        pm_res = modpow(cap_a, cap_b, cap_m);
        @(negedge clk);
        if (!skip_stab) chk("pm_operands_held", int'({pm_a, pm_b, pm_m}), int'({cap_a, cap_b, cap_m}));
        @(posedge clk);
        #1;
        pm_rdy = 1'b0;
      end
    end
  end

  always @(negedge clk) if (pm_start) pm_starts++;
  always @(negedge clk) if (rst && out_valid && out_ready) outq.push_back(out_data);

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic load_key(input logic [7:0] e, input logic [7:0] n);
    key_ld = 1'b1;
    key_e  = e;
    key_n  = n;
    @(posedge clk);
    #1;
    key_ld = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("push_accepted", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 400 && outq.size() < n; i++) @(negedge clk);
    if (outq.size() < n) chk("outputs_arrived", outq.size(), n);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pm_start();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pm_start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("pm_start_seen", 0, 1);
  endtask

  initial begin
    int s0;
    int n;
    vecs[0] = '{e: 8'd7,  n: 8'd187, din: 8'd88,  exp: 8'd11};
    vecs[1] = '{e: 8'd23, n: 8'd187, din: 8'd11,  exp: 8'd88};
    vecs[2] = '{e: 8'd23, n: 8'd187, din: 8'd0,   exp: 8'd0};
    vecs[3] = '{e: 8'd23, n: 8'd187, din: 8'd1,   exp: 8'd1};
    vecs[4] = '{e: 8'd23, n: 8'd187, din: 8'd186, exp: 8'd186};
    vecs[5] = '{e: 8'd0,  n: 8'd187, din: 8'd55,  exp: 8'd1};
    vecs[6] = '{e: 8'd7,  n: 8'd187, din: 8'd200, exp: 8'd106};
    vecs[7] = '{e: 8'd3,  n: 8'd33,  din: 8'd4,   exp: 8'd31};

    rst = 1'b0; key_ld = 1'b0; key_e = '0; key_n = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cfg_err", cfg_err, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pm_start", pm_start, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_pm_b", pm_b, 0);
    chk("rst_pm_m", pm_m, 0);
    chk("rst_tmo_err", tmo_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 0);
    chk("post_rst_cfg_err", cfg_err, 1);
    @(posedge clk);
    #1;

    // Table of single-byte transactions
    core_lat = 1;
    foreach (vecs[k]) begin
      wait_idle();
      load_key(vecs[k].e, vecs[k].n);
      outq.delete();
      s0 = pm_starts;
      push_byte(vecs[k].din);
      wait_out(1);
      chk($sformatf("vec%0d_out", k), (outq.size() > 0) ? int'(outq[0]) : -1, vecs[k].exp);
      chk($sformatf("vec%0d_starts", k), pm_starts - s0, 1);
      chk($sformatf("vec%0d_pm_a", k), cap_a, vecs[k].din);
      chk($sformatf("vec%0d_pm_b", k), cap_b, vecs[k].e);
      chk($sformatf("vec%0d_pm_m", k), cap_m, vecs[k].n);
    end

    // Back-to-back stream, order preserved
    wait_idle();
    core_lat = 2;
    load_key(8'd23, 8'd187);
    outq.delete();
    push_byte(8'd11);
    push_byte(8'd0);
    push_byte(8'd1);
    push_byte(8'd186);
    wait_out(4);
    chk("b2b_count", outq.size(), 4);
    if (outq.size() >= 4) begin
      chk("b2b_0", outq[0], 88);
      chk("b2b_1", outq[1], 0);
      chk("b2b_2", outq[2], 1);
      chk("b2b_3", outq[3], 186);
    end

    // ISSUE to out_valid latency
    wait_idle();
    core_lat = 3;
    load_key(8'd1, 8'd187);
    outq.delete();
    push_byte(8'd42);
    wait_pm_start();
    n = 0;
    for (int i = 0; i < 50 && !out_valid; i++) begin
      @(negedge clk);
      n++;
    end
    chk("issue_to_out_latency", n, core_lat + 1);
    wait_out(1);

    // FIFO full with output stalled
    wait_idle();
    core_lat = 4;
    out_ready = 1'b0;
    outq.delete();
    push_byte(8'd10);
    push_byte(8'd20);
    push_byte(8'd30);
    push_byte(8'd40);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    chk("full_busy", busy, 1);
    push_byte(8'd50);
    @(negedge clk);
    chk("full_again_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_out_data", out_data, 10);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_out(5);
    chk("full_count", outq.size(), 5);
    for (int i = 0; i < 5 && i < outq.size(); i++)
      chk($sformatf("full_order%0d", i), outq[i], (i + 1) * 10);

    // Core timeout drops one byte, next byte proceeds
    wait_idle();
    core_lat = 2;
    core_en = 1'b0;
    outq.delete();
    push_byte(8'd77);
    push_byte(8'd78);
    wait_pm_start();
    @(negedge clk);
    core_en = 1'b1;
    repeat (62) @(negedge clk);
    chk("tmo_not_yet", tmo_err, 0);
    @(negedge clk);
    chk("tmo_set", tmo_err, 1);
    wait_out(1);
    chk("tmo_next_byte", (outq.size() > 0) ? int'(outq[0]) : -1, 78);
    repeat (4) @(negedge clk);
    chk("tmo_drop_count", outq.size(), 1);
    chk("tmo_sticky", tmo_err, 1);

    // Bad modulus blocks input
    wait_idle();
    load_key(8'd1, 8'd1);
    @(negedge clk);
    chk("cfg_err_n1", cfg_err, 1);
    chk("cfg_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 8'd9;
    repeat (3) @(negedge clk);
    chk("cfg_no_push", busy, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    load_key(8'd1, 8'd187);
    @(negedge clk);
    chk("cfg_err_clear", cfg_err, 0);
    @(posedge clk);
    #1;

    // key_ld while busy is ignored
    core_lat = 4;
    outq.delete();
    push_byte(8'd99);
    wait_pm_start();
    @(posedge clk);
    #1;
    load_key(8'd5, 8'd200);
    @(negedge clk);
    chk("busy_key_e", pm_b, 1);
    chk("busy_key_n", pm_m, 187);
    wait_out(1);
    chk("busy_key_out", (outq.size() > 0) ? int'(outq[0]) : -1, 99);

    // Reset mid-WAIT, later stray pm_rdy ignored
    wait_idle();
    core_lat = 10;
    skip_stab = 1'b1;
    push_byte(8'd33);
    wait_pm_start();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_tmo_err", tmo_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    outq.delete();
    repeat (20) @(negedge clk);
    chk("midrst_no_output", outq.size(), 0);
    chk("midrst_busy_after", busy, 0);
    chk("midrst_out_valid_after", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
